// File: rtl/add_window_acc.sv
// add_window_acc: totals WINDOW accepted samples into ACC_W bits with an overflow flag; result valid one cycle after the last sample.
// in_ready drops only when completing a window would overwrite an unread result; ADD_WINDOW_ACC_SAT_EN saturates instead of wrapping.
module add_window_acc #(
  parameter int W      = 15,
  parameter int WINDOW = 16,
  parameter int ACC_W  = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf_out,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             last;
  logic             accept;
  logic             carry;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_nxt;

  assign last     = (cnt == LAST);
  assign in_ready = ~(out_valid & ~out_ready & last);
  assign accept   = in_valid & in_ready;
  assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - W){1'b0}}, sum_in};
  assign carry    = sum_ext[ACC_W];

`ifdef ADD_WINDOW_ACC_SAT_EN
  assign acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      acc_out   <= '0;
      ovf_out   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      // A completing window overrides the consume above, so back-to-back results never bubble.
      if (accept) begin
        if (last) begin
          acc_out   <= acc_nxt;
          ovf_out   <= ovf | carry;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf       <= 1'b0;
          cnt       <= '0;
        end else begin
          acc <= acc_nxt;
          ovf <= ovf | carry;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_add_window_acc.sv
// Bench for add_window_acc: directed cases on a WINDOW=4 and a default instance, then random traffic against a window-sum model.
module tb_add_window_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  localparam longint LIM = 64'd1 << 18;

  logic        rst4, iv4, ir4, ov4, or4, ovf4;
  logic [14:0] sum4;
  logic [17:0] acc4;
  logic        rst16, iv16, ir16, ov16, or16, ovf16;
  logic [14:0] sum16;
  logic [17:0] acc16;

  add_window_acc #(.W(15), .WINDOW(4), .ACC_W(18)) u4 (
    .clk(clk), .rst(rst4), .sum_in(sum4), .in_valid(iv4), .in_ready(ir4),
    .acc_out(acc4), .ovf_out(ovf4), .out_valid(ov4), .out_ready(or4)
  );

  add_window_acc u16 (
    .clk(clk), .rst(rst16), .sum_in(sum16), .in_valid(iv16), .in_ready(ir16),
    .acc_out(acc16), .ovf_out(ovf16), .out_valid(ov16), .out_ready(or16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for the falling edge, then applies inputs for the next rising edge.
  task automatic drive4(input logic v, input logic [14:0] s, input logic r);
    @(negedge clk);
    iv4 = v; sum4 = s; or4 = r;
    #1;
  endtask

  task automatic drive16(input logic v, input logic [14:0] s, input logic r);
    @(negedge clk);
    iv16 = v; sum16 = s; or16 = r;
    #1;
  endtask

  // Expected {ovf, total} of a window from the exact arithmetic sum of its samples.
  function automatic logic [18:0] window_result(input longint total);
    logic        o;
    logic [17:0] a;
    o = (total >= LIM);
`ifdef ADD_WINDOW_ACC_SAT_EN
    a = o ? 18'h3FFFF : 18'(total);
`else
    a = 18'(total % LIM);
`endif
    return {o, a};
  endfunction

  int unsigned win[$];
  logic        pend;
  logic [17:0] pacc;
  logic        povf;

  initial begin
    logic        v, r, exp_ir;
    logic [14:0] s;
    logic [18:0] res;
    longint      total;

    rst4 = 1'b1; iv4 = 1'b0; sum4 = '0; or4 = 1'b0;
    rst16 = 1'b1; iv16 = 1'b0; sum16 = '0; or16 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst4_valid", 32'(ov4), 0);
    check("rst4_acc", 32'(acc4), 0);
    check("rst4_ovf", 32'(ovf4), 0);
    check("rst4_ready", 32'(ir4), 1);
    check("rst16_valid", 32'(ov16), 0);
    check("rst16_ready", 32'(ir16), 1);
    rst4 = 1'b0; rst16 = 1'b0;

    // Basic window of four.
    drive4(1, 10, 1);
    drive4(1, 0, 1);
    drive4(1, 20, 1);
    drive4(1, 30, 1);
    check("t1_not_early", 32'(ov4), 0);
    drive4(0, 0, 1);
    check("t1_valid", 32'(ov4), 1);
    check("t1_acc", 32'(acc4), 60);
    check("t1_ovf", 32'(ovf4), 0);
    drive4(0, 0, 1);
    check("t1_pulse", 32'(ov4), 0);

    // Backpressure: result held, 8th sample stalled until the result is taken.
    for (int i = 0; i < 7; i++) begin
      drive4(1, 5, 0);
      check("t4_ready_early", 32'(ir4), 1);
    end
    drive4(1, 5, 0);
    check("t4_stall", 32'(ir4), 0);
    check("t4_hold_valid", 32'(ov4), 1);
    check("t4_hold_acc", 32'(acc4), 20);
    drive4(1, 5, 0);
    check("t4_stall2", 32'(ir4), 0);
    check("t4_stable_acc", 32'(acc4), 20);
    drive4(1, 5, 1);
    check("t4_release", 32'(ir4), 1);
    drive4(0, 0, 1);
    check("t4_next_valid", 32'(ov4), 1);
    check("t4_next_acc", 32'(acc4), 20);
    drive4(0, 0, 0);
    check("t4_drained", 32'(ov4), 0);

    // Reset discards a partial window and a pending result.
    for (int i = 0; i < 4; i++) drive4(1, 9, 0);
    drive4(1, 100, 0);
    check("t5_pending_acc", 32'(acc4), 36);
    drive4(1, 100, 0);
    drive4(0, 0, 0);
    rst4 = 1'b1;
    drive4(0, 0, 0);
    rst4 = 1'b0;
    check("t5_rst_valid", 32'(ov4), 0);
    check("t5_rst_acc", 32'(acc4), 0);
    check("t5_rst_ovf", 32'(ovf4), 0);
    check("t5_rst_ready", 32'(ir4), 1);
    for (int i = 0; i < 4; i++) drive4(1, 3, 1);
    drive4(0, 0, 1);
    check("t5_valid", 32'(ov4), 1);
    check("t5_acc", 32'(acc4), 12);
    drive4(0, 0, 0);
    check("t5_drained", 32'(ov4), 0);

    // Consume and complete on the same edge.
    for (int i = 0; i < 4; i++) drive4(1, 10, 0);
    for (int i = 0; i < 3; i++) drive4(1, 7, 0);
    drive4(1, 7, 1);
    check("t6_ready", 32'(ir4), 1);
    check("t6_old_acc", 32'(acc4), 40);
    drive4(0, 0, 0);
    check("t6_valid", 32'(ov4), 1);
    check("t6_new_acc", 32'(acc4), 28);
    drive4(0, 0, 1);
    drive4(0, 0, 0);
    check("t6_drained", 32'(ov4), 0);

    // Default window with random idle gaps.
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 3)) begin
        drive16(0, 0, 1);
        check("t2_gap_valid", 32'(ov16), 0);
      end
      drive16(1, 1000, 1);
      check("t2_not_early", 32'(ov16), 0);
    end
    drive16(0, 0, 1);
    check("t2_valid", 32'(ov16), 1);
    check("t2_acc", 32'(acc16), 16000);
    check("t2_ovf", 32'(ovf16), 0);
    drive16(0, 0, 1);
    check("t2_drained", 32'(ov16), 0);

    // Overflowing window.
    for (int k = 0; k < 16; k++) drive16(1, 15'd32767, 1);
    drive16(0, 0, 1);
    check("t3_valid", 32'(ov16), 1);
`ifdef ADD_WINDOW_ACC_SAT_EN
    check("t3_acc", 32'(acc16), 262143);
`else
    check("t3_acc", 32'(acc16), 262128);
`endif
    check("t3_ovf", 32'(ovf16), 1);
    drive16(0, 0, 1);
    check("t3_drained", 32'(ov16), 0);

    // Random traffic against the window-sum model.
    pend = 1'b0; pacc = '0; povf = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      check("rnd_valid", 32'(ov16), 32'(pend));
      if (pend) begin
        check("rnd_acc", 32'(acc16), 32'(pacc));
        check("rnd_ovf", 32'(ovf16), 32'(povf));
      end
      v = ($urandom_range(0, 3) != 0);
      s = 15'($urandom_range(0, 32767));
      r = ($urandom_range(0, 2) == 0);
      iv16 = v; sum16 = s; or16 = r;
      #1;
      exp_ir = !(pend && !r && win.size() == 15);
      check("rnd_ready", 32'(ir16), 32'(exp_ir));
      if (pend && r) pend = 1'b0;
      if (v && exp_ir) begin
        win.push_back(32'(s));
        if (win.size() == 16) begin
          total = 0;
          foreach (win[i]) total += longint'(win[i]);
          res  = window_result(total);
          pacc = res[17:0];
          povf = res[18];
          pend = 1'b1;
          win.delete();
        end
      end
    end
    iv16 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
